// File: rtl/spi_flash_slave.sv
// spi_flash_slave
//   Mode-0 SPI slave that emulates the read side of a serial NOR flash:
//   READ (03h) with gapless streaming from an external byte memory,
//   JEDEC ID (9Eh/9Fh) and READ STATUS (05h, never busy). Any other
//   opcode is captured and the rest of the frame is ignored.
//
// Ports
//   sclk        SPI clock; mosi sampled on rising edge, miso updated on falling edge
//   rst_n       asynchronous active-low reset
//   cs_n        active-low chip select; high holds the frame logic idle
//   mosi        serial data in, MSB first
//   miso        serial data out, MSB first
//   miso_oe     high while miso carries response data
//   mem_addr    byte address to the backing memory (kept across frames)
//   mem_rd_en   one-sclk-period read strobe
//   mem_rd_data memory byte, valid by the falling edge after mem_rd_en rises
//   cmd         last captured command byte (kept across frames)
//   cmd_valid   one-sclk-period pulse after command capture
module spi_flash_slave #(
  parameter logic [7:0] ID_B0 = 8'h20,
  parameter logic [7:0] ID_B1 = 8'hBA,
  parameter logic [7:0] ID_B2 = 8'h16
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic [23:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rd_data,
  output logic [7:0]  cmd,
  output logic        cmd_valid
);

  typedef enum logic [2:0] {
    ST_CMD, ST_ADDR, ST_RD_DATA, ST_ID_OUT, ST_STAT_OUT, ST_IGNORE
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  rx_reg;
  logic [7:0]  rx_next;
  logic        byte_done;
  logic [1:0]  addr_byte_reg;
  logic [15:0] addr_hi_reg;
  logic [1:0]  id_idx_reg;
  logic [6:0]  tx_reg;
  logic [7:0]  load_byte;
  logic        resp_active;
  logic        hold;

  // Frame logic is held idle either by reset or by a deselected chip.
  assign hold      = ~rst_n | cs_n;
  assign rx_next   = {rx_reg[6:0], mosi};
  assign byte_done = (bit_cnt_reg == 3'd7);

  // ID table: three JEDEC bytes followed by zero padding.
  localparam logic [31:0] ID_WORD = {ID_B0, ID_B1, ID_B2, 8'h00};
  logic [7:0] id_rom [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_id_rom
      assign id_rom[gi] = ID_WORD[31-8*gi -: 8];
    end
  endgenerate

  // Next-state decode
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CMD: begin
        if (byte_done) begin
          case (rx_next)
            8'h03:        state_next = ST_ADDR;
            8'h9E, 8'h9F: state_next = ST_ID_OUT;
            8'h05:        state_next = ST_STAT_OUT;
            default:      state_next = ST_IGNORE;
          endcase
        end
      end
      ST_ADDR: begin
        if (byte_done && addr_byte_reg == 2'd2) state_next = ST_RD_DATA;
      end
      default: state_next = state_reg;
    endcase
  end

  // Rising-edge frame logic (cleared whenever cs_n is high)
  always_ff @(posedge sclk or posedge hold) begin
    if (hold) begin
      state_reg     <= ST_CMD;
      bit_cnt_reg   <= 3'd0;
      rx_reg        <= 8'h00;
      cmd_valid     <= 1'b0;
      mem_rd_en     <= 1'b0;
      addr_byte_reg <= 2'd0;
      addr_hi_reg   <= 16'h0000;
      id_idx_reg    <= 2'd0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_reg + 3'd1;
      rx_reg      <= rx_next;
      cmd_valid   <= (state_reg == ST_CMD) && byte_done;
      // Strobe for the first byte at the end of the address, then one per
      // completed output byte so the next byte is ready at the boundary.
      mem_rd_en   <= byte_done &&
                     ((state_reg == ST_ADDR && addr_byte_reg == 2'd2) ||
                      state_reg == ST_RD_DATA);
      if (state_reg == ST_ADDR && byte_done) begin
        addr_byte_reg <= addr_byte_reg + 2'd1;
        if (addr_byte_reg == 2'd0) addr_hi_reg[15:8] <= rx_next;
        else if (addr_byte_reg == 2'd1) addr_hi_reg[7:0] <= rx_next;
      end
      // Saturate on the zero-padding entry.
      if (state_reg == ST_ID_OUT && byte_done && id_idx_reg != 2'd3)
        id_idx_reg <= id_idx_reg + 2'd1;
    end
  end

  // Values that survive chip deselect; only rst_n clears them.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= 8'h00;
      mem_addr <= 24'h000000;
    end else if (!cs_n) begin
      if (state_reg == ST_CMD && byte_done)
        cmd <= rx_next;
      // The address is committed only once complete, so an aborted frame
      // leaves the previous address intact.
      if (state_reg == ST_ADDR && byte_done && addr_byte_reg == 2'd2)
        mem_addr <= {addr_hi_reg, rx_next};
      else if (state_reg == ST_RD_DATA && byte_done)
        mem_addr <= mem_addr + 24'd1;
    end
  end

  assign resp_active = (state_reg == ST_RD_DATA) || (state_reg == ST_ID_OUT) ||
                       (state_reg == ST_STAT_OUT);

  always_comb begin
    load_byte = 8'h00;
    case (state_reg)
      ST_RD_DATA: load_byte = mem_rd_data;
      ST_ID_OUT:  load_byte = id_rom[id_idx_reg];
      default:    load_byte = 8'h00;
    endcase
  end

  // Falling-edge transmit path. bit_cnt_reg == 0 here means a byte boundary
  // has just been crossed on the preceding rising edge.
  always_ff @(negedge sclk or posedge hold) begin
    if (hold) begin
      tx_reg  <= 7'h00;
      miso    <= 1'b0;
      miso_oe <= 1'b0;
    end else if (resp_active) begin
      if (bit_cnt_reg == 3'd0) begin
        miso    <= load_byte[7];
        tx_reg  <= load_byte[6:0];
        miso_oe <= 1'b1;
      end else begin
        miso    <= tx_reg[6];
        tx_reg  <= {tx_reg[5:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_slave.sv
// tb_spi_flash_slave
//   Directed and randomized frames against a byte-level model of the
//   flash command set (expected response bytes, output-enable window,
//   read address sequence).
module tb_spi_flash_slave;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        miso_oe;
  logic [23:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_data = 8'h00;
  logic [7:0]  cmd;
  logic        cmd_valid;

  int errors = 0;
  int checks = 0;

  bit          mosi_q[$];
  bit          miso_q[$];
  bit          oe_q[$];
  logic [23:0] rd_q[$];
  int          cv_cnt;

  spi_flash_slave dut (
    .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .cmd(cmd), .cmd_valid(cmd_valid)
  );

  function automatic logic [7:0] mem_fn(input logic [23:0] a);
    if (a == 24'h000100) return 8'hA5;
    if (a == 24'h000101) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ ~a[23:16] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [7:0] c, input logic [23:0] a, input int k);
    logic [23:0] ak;
    ak = a + k[23:0];
    if (c == 8'h03) return mem_fn(ak);
    if (c == 8'h9E || c == 8'h9F) begin
      if (k == 0) return 8'h20;
      if (k == 1) return 8'hBA;
      if (k == 2) return 8'h16;
      return 8'h00;
    end
    return 8'h00;
  endfunction

  function automatic bit is_known(input logic [7:0] c);
    return c == 8'h03 || c == 8'h9E || c == 8'h9F || c == 8'h05;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SPI bit: master drives mosi in the low phase, samples miso just
  // before the rising edge, and the memory answers a strobe after it.
  task automatic clk_bit(input bit b);
    sclk = 1'b0;
    mosi = b;
    #4;
    miso_q.push_back(miso);
    oe_q.push_back(miso_oe);
    #1 sclk = 1'b1;
    #1;
    if (cmd_valid) cv_cnt++;
    if (mem_rd_en) begin
      rd_q.push_back(mem_addr);
      mem_rd_data = mem_fn(mem_addr);
    end
    #4;
  endtask

  task automatic build(input logic [7:0] c, input logic [23:0] a, input int nbytes);
    mosi_q.delete();
    for (int i = 7; i >= 0; i--) mosi_q.push_back(c[i]);
    if (c == 8'h03) for (int i = 23; i >= 0; i--) mosi_q.push_back(a[i]);
    for (int i = 0; i < 8 * nbytes; i++) mosi_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic start_frame();
    miso_q.delete();
    oe_q.delete();
    rd_q.delete();
    cv_cnt = 0;
    cs_n = 1'b0;
    #5;
  endtask

  task automatic run_frame();
    start_frame();
    foreach (mosi_q[i]) clk_bit(mosi_q[i]);
    #1 sclk = 1'b0;
    #4 cs_n = 1'b1;
    #10;
  endtask

  task automatic do_frame(input logic [7:0] c, input logic [23:0] a, input int n, input string tag);
    bit          resp;
    int          rs;
    int          bad;
    logic [7:0]  got;
    logic [23:0] ak;
    resp = is_known(c);
    rs   = (c == 8'h03) ? 32 : 8;
    build(c, a, n);
    run_frame();
    $display("frame %s cmd=%02h addr=%06h bytes=%0d", tag, c, a, n);
    check({tag, ".cmd"}, 32'(cmd), 32'(c));
    check({tag, ".cmd_valid_pulses"}, cv_cnt, 1);
    bad = 0;
    foreach (oe_q[i]) if (oe_q[i] !== (resp && i >= rs)) bad++;
    check({tag, ".oe_window_errs"}, bad, 0);
    if (resp) begin
      for (int k = 0; k < n; k++) begin
        got = 8'h00;
        for (int j = 0; j < 8; j++) got = {got[6:0], miso_q[rs + 8 * k + j]};
        check($sformatf("%s.byte%0d", tag, k), 32'(got), 32'(exp_byte(c, a, k)));
      end
    end else begin
      bad = 0;
      foreach (miso_q[i]) if (miso_q[i] !== 1'b0) bad++;
      check({tag, ".ignore_miso_ones"}, bad, 0);
    end
    if (c == 8'h03) begin
      check({tag, ".nreads"}, rd_q.size(), n + 1);
      for (int k = 0; k <= n && k < rd_q.size(); k++) begin
        ak = a + k[23:0];
        check($sformatf("%s.rd_addr%0d", tag, k), 32'(rd_q[k]), 32'(ak));
      end
      ak = a + n[23:0];
      check({tag, ".mem_addr_end"}, 32'(mem_addr), 32'(ak));
    end
  endtask

  initial begin
    logic [7:0]  c;
    logic [23:0] a;
    int          r;

    // Reset state
    #20;
    check("rst.miso", 32'(miso), 0);
    check("rst.miso_oe", 32'(miso_oe), 0);
    check("rst.mem_rd_en", 32'(mem_rd_en), 0);
    check("rst.cmd_valid", 32'(cmd_valid), 0);
    check("rst.cmd", 32'(cmd), 0);
    check("rst.mem_addr", 32'(mem_addr), 0);
    rst_n = 1'b1;
    #10;

    // Directed scenarios
    do_frame(8'h9E, 24'h0, 3, "jedec9e");
    do_frame(8'h03, 24'h000100, 2, "read100");
    do_frame(8'h03, 24'hFFFFFF, 2, "readwrap");
    do_frame(8'hAB, 24'h0, 3, "ignoreab");

    // Aborted command after 5 bits, then a status read
    build(8'h9F, 24'h0, 0);
    mosi_q = mosi_q[0:4];
    run_frame();
    $display("frame partial9f bits=5");
    check("partial.cmd_kept", 32'(cmd), 32'h000000AB);
    check("partial.cmd_valid_pulses", cv_cnt, 0);
    check("partial.mem_addr_kept", 32'(mem_addr), 32'h00000001);
    do_frame(8'h05, 24'h0, 2, "status05");

    // Randomized frames
    for (int t = 0; t < 16; t++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: c = 8'h03;
        1: c = 8'h9E;
        2: c = 8'h9F;
        3: c = 8'h05;
        default: begin
          c = 8'($urandom_range(0, 255));
          while (is_known(c)) c = 8'($urandom_range(0, 255));
        end
      endcase
      a = 24'($urandom());
      if (t == 0) a = 24'hFFFFFE;
      do_frame(c, a, $urandom_range(1, 4), $sformatf("rand%0d", t));
    end

    // Reset pulsed in the middle of a read stream
    build(8'h03, 24'h001234, 2);
    start_frame();
    for (int i = 0; i < 40; i++) clk_bit(mosi_q[i]);
    $display("frame midreset cmd=03 addr=001234 bits=40");
    check("midrst.pre_oe", 32'(oe_q[39]), 1);
    check("midrst.pre_rd_en", 32'(mem_rd_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.miso", 32'(miso), 0);
    check("midrst.miso_oe", 32'(miso_oe), 0);
    check("midrst.mem_rd_en", 32'(mem_rd_en), 0);
    check("midrst.cmd_valid", 32'(cmd_valid), 0);
    check("midrst.cmd", 32'(cmd), 0);
    check("midrst.mem_addr", 32'(mem_addr), 0);
    #1 sclk = 1'b0;
    cs_n = 1'b1;
    #5 rst_n = 1'b1;
    #10;
    do_frame(8'h9E, 24'h0, 1, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_slave.md
SPI_FLASH_SLAVE -- requirements
Module: spi_flash_slave

Interface
REQ-001 SHALL have parameter ID_B0, default 8'h20, meaning first JEDEC ID byte.
REQ-002 SHALL have parameter ID_B1, default 8'hBA, meaning second JEDEC ID byte.
REQ-003 SHALL have parameter ID_B2, default 8'h16, meaning third JEDEC ID byte.
REQ-004 SHALL have port sclk, input, 1, SPI serial clock: rising edge samples mosi, falling edge updates miso (mode 0).
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cs_n, input, 1, active-low chip select framing each transaction.
REQ-007 SHALL have port mosi, input, 1, serial data from master, MSB first.
REQ-008 SHALL have port miso, output, 1, serial data to master, MSB first.
REQ-009 SHALL have port miso_oe, output, 1, high while miso carries response data.
REQ-010 SHALL have port mem_addr, output, 24, byte address to backing memory.
REQ-011 SHALL have port mem_rd_en, output, 1, one-sclk-period read strobe.
REQ-012 SHALL have port mem_rd_data, input, 8, memory byte, valid by the sclk falling edge after mem_rd_en rises.
REQ-013 SHALL have port cmd, output, 8, last captured command byte.
REQ-014 SHALL have port cmd_valid, output, 1, high for one sclk period after command capture.

Function
REQ-015 SHALL implement states CMD, ADDR, RD_DATA, ID_OUT, STAT_OUT, IGNORE.
REQ-016 SHALL, while cs_n high, asynchronously hold state=CMD, bit counter=0, miso=0, miso_oe=0, mem_rd_en=0, cmd_valid=0.
REQ-017 SHALL shift mosi into an 8-bit receive register on each sclk rising edge with cs_n low; 3-bit bit counter wraps 7->0.
REQ-018 SHALL in CMD, on the 8th rising edge, load cmd, pulse cmd_valid, and decode: 8'h03->ADDR, 8'h9E or 8'h9F->ID_OUT, 8'h05->STAT_OUT, any other->IGNORE.
REQ-019 SHALL in ADDR collect 24 address bits MSB first into mem_addr; on the 24th address rising edge assert mem_rd_en and go to RD_DATA.
REQ-020 SHALL in RD_DATA load mem_rd_data into the transmit shifter on the falling edge following mem_rd_en, drive its MSB on miso, shift one bit per falling edge thereafter.
REQ-021 SHALL in RD_DATA, on the rising edge ending each output byte's 8th bit, increment mem_addr by 1 (24-bit wrap 24'hFFFFFF->24'h000000) and pulse mem_rd_en for the next byte, giving gapless streaming.
REQ-022 SHALL in ID_OUT transmit ID_B0, ID_B1, ID_B2 in order starting on the falling edge after command capture, then 8'h00 for all further bytes.
REQ-023 SHALL in STAT_OUT transmit 8'h00 repeatedly (never busy).
REQ-024 SHALL in IGNORE drive miso_oe=0, miso=0 and discard mosi until cs_n rises.
REQ-025 SHALL hold miso_oe=1 from the first response falling edge until cs_n rises.
REQ-026 SHALL abandon any partial command, address or data byte when cs_n rises mid-byte; next frame starts in CMD with counter 0.
REQ-027 SHALL keep mem_addr and cmd values across cs_n deassertion (only rst_n clears them).
REQ-028 SHALL ignore mosi while in RD_DATA, ID_OUT and STAT_OUT.

Reset
REQ-029 SHALL on rst_n low asynchronously set state=CMD, bit counter=0, miso=0, miso_oe=0, mem_addr=24'h0, mem_rd_en=0, cmd=8'h00, cmd_valid=0.
REQ-030 SHALL resume operation on the first sclk rising edge with cs_n low after rst_n deasserts; reset asserted mid-frame behaves as REQ-029 immediately.

Verification
REQ-031 SHALL pass: cs_n low, shift 8'h9E, 24 more clocks -> cmd=8'h9E, cmd_valid one pulse, miso bytes 8'h20, 8'hBA, 8'h16.
REQ-032 SHALL pass: shift 8'h03, address 24'h000100, memory returns 8'hA5, 8'h5A -> mem_rd_en at 24'h000100 and 24'h000101, miso 8'hA5 then 8'h5A with no gap.
REQ-033 SHALL pass: read from 24'hFFFFFF for 2 bytes -> mem_addr 24'hFFFFFF then 24'h000000.
REQ-034 SHALL pass: shift 8'hAB -> cmd=8'hAB, miso_oe stays 0 for rest of frame.
REQ-035 SHALL pass: cs_n raised after 5 command bits, new frame 8'h05 -> first frame discarded, second yields miso 8'h00, miso_oe=1.
REQ-036 SHALL pass: rst_n pulsed low mid-RD_DATA -> all outputs at REQ-029 values immediately; next frame 8'h9E returns 8'h20 first.
